// File: rtl/reg_operand_pkg_8088.sv
// Shared types for the 8088 register operand sequencer: FSM states,
// register code constants and the code-to-bank mapping function.
package reg_operand_pkg_8088;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_WB       = 3'd4
  } state_e;

  localparam logic [2:0] REG_AX = 3'd0;
  localparam logic [2:0] REG_CX = 3'd1;
  localparam logic [2:0] REG_DX = 3'd2;
  localparam logic [2:0] REG_BX = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  localparam logic [2:0] REG_SI = 3'd6;
  localparam logic [2:0] REG_DI = 3'd7;

  localparam logic [2:0] REG_AL = 3'd0;
  localparam logic [2:0] REG_CL = 3'd1;
  localparam logic [2:0] REG_DL = 3'd2;
  localparam logic [2:0] REG_BL = 3'd3;
  localparam logic [2:0] REG_AH = 3'd4;
  localparam logic [2:0] REG_CH = 3'd5;
  localparam logic [2:0] REG_DH = 3'd6;
  localparam logic [2:0] REG_BH = 3'd7;

  typedef struct packed {
    logic [2:0] idx;
    logic       high;
  } reg_map_t;

  // Byte codes 4..7 alias the upper halves of AX..BX.
  function automatic reg_map_t map_reg(input logic [2:0] code, input logic word);
    reg_map_t m;
    if (word) begin
      m.idx  = code;
      m.high = 1'b0;
    end else begin
      m.idx  = {1'b0, code[1:0]};
      m.high = code[2];
    end
    return m;
  endfunction

endpackage

// File: rtl/reg_operand_unit_8088_byte_lane.sv
// Read-port lane extractor: passes a word through, or picks one byte
// and zero-extends it.
module reg_byte_lane_8088 (
  input  logic [15:0] data_in,
  input  logic        word,
  input  logic        high,
  output logic [15:0] data_out
);

  // Select full word or one zero-extended byte lane.
  always_comb begin
    data_out = data_in;
    if (word) begin
      data_out = data_in;
    end else if (high) begin
      data_out = {8'h00, data_in[15:8]};
    end else begin
      data_out = {8'h00, data_in[7:0]};
    end
  end

endmodule

// File: rtl/reg_operand_unit_8088.sv
// Operand sequencer: reads two sources from the register bank, hands them to
// the ALU and optionally writes the ALU result back to the destination.
module reg_operand_unit_8088 #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_w,
  input  logic [2:0]       req_src1,
  input  logic [2:0]       req_src2,
  input  logic [2:0]       req_dst,
  input  logic             req_wb,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [15:0]      op_a,
  output logic [15:0]      op_b,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [15:0]      res_data,
  output logic [2:0]       rb_reg_read1,
  output logic [2:0]       rb_reg_read2,
  input  logic [15:0]      rb_read_data1,
  input  logic [15:0]      rb_read_data2,
  output logic             rb_en_write,
  output logic [2:0]       rb_reg_write,
  output logic [15:0]      rb_write_data,
  output logic             rb_size,
  output logic             rb_select_high_low,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clear,
  output logic [CNT_W-1:0] wb_count
);
  import reg_operand_pkg_8088::*;

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  logic w_q, w_d, wb_q, wb_d, hi1_q, hi1_d, hi2_q, hi2_d, dst_hi_q, dst_hi_d;
  logic [2:0] rd1_q, rd1_d, rd2_q, rd2_d, dst_idx_q, dst_idx_d, wr_idx_q, wr_idx_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d, wr_data_q, wr_data_d;
  logic en_wr_q, en_wr_d, size_q, size_d, sel_hl_q, sel_hl_d;
  logic req_ready_q, req_ready_d, op_valid_q, op_valid_d, res_ready_q, res_ready_d;
  logic busy_q, busy_d, err_q, err_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [15:0] ext1_s, ext2_s;
  reg_map_t map1_s, map2_s, mapd_s;

  assign map1_s = map_reg(req_src1, req_w);
  assign map2_s = map_reg(req_src2, req_w);
  assign mapd_s = map_reg(req_dst, req_w);

  reg_byte_lane_8088 u_lane1 (.data_in(rb_read_data1), .word(w_q), .high(hi1_q), .data_out(ext1_s));
  reg_byte_lane_8088 u_lane2 (.data_in(rb_read_data2), .word(w_q), .high(hi2_q), .data_out(ext2_s));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d = state_q;     w_d = w_q;         wb_d = wb_q;
    hi1_d = hi1_q;         hi2_d = hi2_q;     dst_hi_d = dst_hi_q;
    rd1_d = rd1_q;         rd2_d = rd2_q;     dst_idx_d = dst_idx_q;
    op_a_d = op_a_q;       op_b_d = op_b_q;   timer_d = timer_q;
    en_wr_d = 1'b0;        wr_idx_d = wr_idx_q; wr_data_d = wr_data_q;
    size_d = size_q;       sel_hl_d = sel_hl_q; wb_cnt_d = wb_cnt_q;
    err_d = err_clear ? 1'b0 : err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          w_d = req_w;           wb_d = req_wb;
          rd1_d = map1_s.idx;    hi1_d = map1_s.high;
          rd2_d = map2_s.idx;    hi2_d = map2_s.high;
          dst_idx_d = mapd_s.idx; dst_hi_d = mapd_s.high;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        op_a_d  = ext1_s;
        op_b_d  = ext2_s;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        timer_d = {TMR_W{1'b0}};
        if (op_ready) begin
          state_d = wb_q ? ST_WAIT_RES : ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RES: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (res_valid) begin
          en_wr_d   = 1'b1;
          wr_idx_d  = dst_idx_q;
          size_d    = w_q;
          sel_hl_d  = dst_hi_q;
          wr_data_d = w_q ? res_data : {8'h00, res_data[7:0]};
          state_d   = ST_WB;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WB: begin
        wb_cnt_d = wb_cnt_q + CNT_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    op_valid_d  = (state_d == ST_ISSUE);
    res_ready_d = (state_d == ST_WAIT_RES);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;  w_q <= 1'b0;      wb_q <= 1'b0;
      hi1_q <= 1'b0;       hi2_q <= 1'b0;    dst_hi_q <= 1'b0;
      rd1_q <= 3'd0;       rd2_q <= 3'd0;    dst_idx_q <= 3'd0;
      op_a_q <= 16'h0000;  op_b_q <= 16'h0000; timer_q <= {TMR_W{1'b0}};
      en_wr_q <= 1'b0;     wr_idx_q <= 3'd0; wr_data_q <= 16'h0000;
      size_q <= 1'b0;      sel_hl_q <= 1'b0; wb_cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;       req_ready_q <= 1'b1; op_valid_q <= 1'b0;
      res_ready_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d;  w_q <= w_d;       wb_q <= wb_d;
      hi1_q <= hi1_d;      hi2_q <= hi2_d;   dst_hi_q <= dst_hi_d;
      rd1_q <= rd1_d;      rd2_q <= rd2_d;   dst_idx_q <= dst_idx_d;
      op_a_q <= op_a_d;    op_b_q <= op_b_d; timer_q <= timer_d;
      en_wr_q <= en_wr_d;  wr_idx_q <= wr_idx_d; wr_data_q <= wr_data_d;
      size_q <= size_d;    sel_hl_q <= sel_hl_d; wb_cnt_q <= wb_cnt_d;
      err_q <= err_d;      req_ready_q <= req_ready_d; op_valid_q <= op_valid_d;
      res_ready_q <= res_ready_d; busy_q <= busy_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign op_valid           = op_valid_q;
  assign res_ready          = res_ready_q;
  assign busy               = busy_q;
  assign op_a               = op_a_q;
  assign op_b               = op_b_q;
  assign rb_reg_read1       = rd1_q;
  assign rb_reg_read2       = rd2_q;
  assign rb_en_write        = en_wr_q;
  assign rb_reg_write       = wr_idx_q;
  assign rb_write_data      = wr_data_q;
  assign rb_size            = size_q;
  assign rb_select_high_low = sel_hl_q;
  assign err_timeout        = err_q;
  assign wb_count           = wb_cnt_q;

endmodule

// File: tb/tb_reg_operand_unit_8088.sv
// Bench for reg_operand_unit_8088 with a behavioural register bank and
// queue-based scoreboards for operands and bank writes.
module tb_reg_operand_unit_8088;
  import reg_operand_pkg_8088::*;

  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_w = 1'b0, req_wb = 1'b0;
  logic [2:0] req_src1 = 3'd0, req_src2 = 3'd0, req_dst = 3'd0;
  logic op_ready = 1'b0, res_valid = 1'b0, err_clear = 1'b0;
  logic [15:0] res_data = 16'h0000;
  logic req_ready, op_valid, res_ready, busy, err_timeout;
  logic rb_en_write, rb_size, rb_select_high_low;
  logic [15:0] op_a, op_b, rb_read_data1, rb_read_data2, rb_write_data;
  logic [2:0] rb_reg_read1, rb_reg_read2, rb_reg_write;
  logic [7:0] wb_count;

  logic [15:0] bank [8];
  logic load_en = 1'b0;
  logic [2:0] load_idx = 3'd0;
  logic [15:0] load_val = 16'h0000;

  typedef struct packed { logic [15:0] a; logic [15:0] b; } op_exp_t;
  typedef struct packed { logic [2:0] idx; logic size; logic hl; logic [15:0] data; } wr_exp_t;
  op_exp_t op_q[$];
  wr_exp_t wr_q[$];
  int n_cmp = 0, n_bad = 0;

  reg_operand_unit_8088 #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_w(req_w), .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .req_wb(req_wb), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a),
    .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rb_reg_read1(rb_reg_read1), .rb_reg_read2(rb_reg_read2),
    .rb_read_data1(rb_read_data1), .rb_read_data2(rb_read_data2),
    .rb_en_write(rb_en_write), .rb_reg_write(rb_reg_write),
    .rb_write_data(rb_write_data), .rb_size(rb_size),
    .rb_select_high_low(rb_select_high_low), .busy(busy),
    .err_timeout(err_timeout), .err_clear(err_clear), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  assign rb_read_data1 = bank[rb_reg_read1];
  assign rb_read_data2 = bank[rb_reg_read2];

  // Behavioural register bank: preload port plus word/byte write port.
  always @(posedge clk) begin
    if (load_en) bank[load_idx] <= load_val;
    else if (rb_en_write) begin
      if (rb_size) bank[rb_reg_write] <= rb_write_data;
      else if (rb_select_high_low) bank[rb_reg_write][15:8] <= rb_write_data[7:0];
      else bank[rb_reg_write][7:0] <= rb_write_data[7:0];
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk); load_en = 1'b1; load_idx = idx; load_val = val;
    @(negedge clk); load_en = 1'b0;
  endtask

  // Waits (bounded) for req_ready, then presents one request for one edge.
  task automatic send_req(input logic w, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [2:0] d, input logic wb, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready === 1'b1) ok = 1'b1; else @(negedge clk);
    end
    req_w = w; req_src1 = s1; req_src2 = s2; req_dst = d; req_wb = wb;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_op_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (op_valid === 1'b1) ok = 1'b1; else @(negedge clk);
    end
  endtask

  task automatic issue_ops();
    op_ready = 1'b1; @(negedge clk); op_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_ready, op_valid, res_ready, busy, rb_en_write, err_timeout} !== 6'b100000 ||
        wb_count !== 8'd0 || op_a !== 16'h0000 || op_b !== 16'h0000) begin
      n_bad++; $display("FAIL reset_hold: got rdy=%b ov=%b bsy=%b we=%b err=%b cnt=%0d need 1,0,0,0,0,0",
                        req_ready, op_valid, busy, rb_en_write, err_timeout, wb_count);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, op_valid, busy, rb_en_write, err_timeout} !== 5'b10000 || wb_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_release: got rdy=%b ov=%b bsy=%b we=%b err=%b cnt=%0d",
                        req_ready, op_valid, busy, rb_en_write, err_timeout, wb_count);
    end
  endtask

  task automatic test_word_stall();
    bit ok; op_exp_t e;
    preload(3'd2, 16'h1234); preload(3'd3, 16'hABCD);
    op_q.push_back('{a: 16'h1234, b: 16'hABCD});
    send_req(1'b1, REG_DX, REG_BX, REG_AX, 1'b0, ok);
    n_cmp++;
    if (!ok || op_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL latency_first_edge: ok=%0d op_valid=%b busy=%b need 1,0,1", ok, op_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (op_valid !== 1'b1) begin
      n_bad++; $display("FAIL latency_second_edge: op_valid=%b need 1", op_valid);
    end
    e = op_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (op_valid !== 1'b1 || op_a !== e.a || op_b !== e.b) begin
        n_bad++; $display("FAIL stall_hold[%0d]: ov=%b a=%h b=%h need 1 %h %h", i, op_valid, op_a, op_b, e.a, e.b);
      end
      if (i < 3) @(negedge clk);
    end
    issue_ops();
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || op_valid !== 1'b0) begin
      n_bad++; $display("FAIL word_back_idle: rdy=%b busy=%b ov=%b need 1,0,0", req_ready, busy, op_valid);
    end
  endtask

  task automatic test_byte_read();
    bit ok; op_exp_t e;
    preload(3'd0, 16'h5A3C);
    op_q.push_back('{a: 16'h005A, b: 16'h003C});
    send_req(1'b0, REG_AH, REG_AL, REG_AL, 1'b0, ok);
    wait_op_valid(ok);
    e = op_q.pop_front();
    n_cmp++;
    if (!ok || op_a !== e.a || op_b !== e.b) begin
      n_bad++; $display("FAIL byte_read: ok=%0d a=%h b=%h need %h %h", ok, op_a, op_b, e.a, e.b);
    end
    issue_ops();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL byte_back_idle: rdy=%b need 1", req_ready);
    end
  endtask

  task automatic test_byte_wb();
    bit ok; op_exp_t e; wr_exp_t w; int writes;
    preload(3'd3, 16'hABCD); preload(3'd1, 16'h0F0F);
    op_q.push_back('{a: 16'h00CD, b: 16'h000F});
    wr_q.push_back('{idx: 3'd3, size: 1'b0, hl: 1'b1, data: 16'h0099});
    send_req(1'b0, REG_BL, REG_CL, REG_BH, 1'b1, ok);
    wait_op_valid(ok);
    e = op_q.pop_front();
    n_cmp++;
    if (!ok || op_a !== e.a || op_b !== e.b) begin
      n_bad++; $display("FAIL bytewb_ops: ok=%0d a=%h b=%h need %h %h", ok, op_a, op_b, e.a, e.b);
    end
    issue_ops();
    n_cmp++;
    if (res_ready !== 1'b1 || rb_en_write !== 1'b0) begin
      n_bad++; $display("FAIL bytewb_wait: res_ready=%b we=%b need 1,0", res_ready, rb_en_write);
    end
    res_valid = 1'b1; res_data = 16'hFF99;
    @(negedge clk);
    res_valid = 1'b0; res_data = 16'h0000;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      if (rb_en_write === 1'b1) begin
        writes++;
        if (writes == 1 && wr_q.size() > 0) begin
          w = wr_q.pop_front();
          n_cmp++;
          if ({rb_reg_write, rb_size, rb_select_high_low, rb_write_data} !== {w.idx, w.size, w.hl, w.data}) begin
            n_bad++; $display("FAIL bytewb_ctrl: idx=%0d sz=%b hl=%b d=%h need %0d %b %b %h",
                              rb_reg_write, rb_size, rb_select_high_low, rb_write_data, w.idx, w.size, w.hl, w.data);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (writes != 1 || bank[3] !== 16'h99CD || wb_count !== 8'd1) begin
      n_bad++; $display("FAIL bytewb_result: writes=%0d bank3=%h cnt=%0d need 1 99cd 1", writes, bank[3], wb_count);
    end
  endtask

  task automatic test_res_at_expiry();
    bit ok; op_exp_t e; wr_exp_t w;
    op_q.push_back('{a: 16'h1234, b: 16'h99CD});
    wr_q.push_back('{idx: 3'd6, size: 1'b1, hl: 1'b0, data: 16'h7E57});
    send_req(1'b1, REG_DX, REG_BX, REG_SI, 1'b1, ok);
    wait_op_valid(ok);
    e = op_q.pop_front();
    n_cmp++;
    if (!ok || op_a !== e.a || op_b !== e.b) begin
      n_bad++; $display("FAIL expiry_ops: ok=%0d a=%h b=%h need %h %h", ok, op_a, op_b, e.a, e.b);
    end
    issue_ops();
    repeat (15) @(negedge clk);
    n_cmp++;
    if (res_ready !== 1'b1 || err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL expiry_still_waiting: res_ready=%b err=%b need 1,0", res_ready, err_timeout);
    end
    res_valid = 1'b1; res_data = 16'h7E57;
    @(negedge clk);
    res_valid = 1'b0;
    w = wr_q.pop_front();
    n_cmp++;
    if (rb_en_write !== 1'b1 || err_timeout !== 1'b0 ||
        {rb_reg_write, rb_size, rb_select_high_low, rb_write_data} !== {w.idx, w.size, w.hl, w.data}) begin
      n_bad++; $display("FAIL expiry_priority: we=%b err=%b idx=%0d sz=%b d=%h need 1 0 %0d %b %h",
                        rb_en_write, err_timeout, rb_reg_write, rb_size, rb_write_data, w.idx, w.size, w.data);
    end
    @(negedge clk);
    n_cmp++;
    if (bank[6] !== 16'h7E57 || wb_count !== 8'd2) begin
      n_bad++; $display("FAIL expiry_result: bank6=%h cnt=%0d need 7e57 2", bank[6], wb_count);
    end
  endtask

  task automatic test_timeout();
    bit ok; bit saw_write; op_exp_t e;
    preload(3'd7, 16'hC0DE);
    op_q.push_back('{a: 16'h1234, b: 16'h99CD});
    send_req(1'b1, REG_DX, REG_BX, REG_DI, 1'b1, ok);
    wait_op_valid(ok);
    e = op_q.pop_front();
    n_cmp++;
    if (!ok || op_a !== e.a || op_b !== e.b) begin
      n_bad++; $display("FAIL timeout_ops: ok=%0d a=%h b=%h need %h %h", ok, op_a, op_b, e.a, e.b);
    end
    issue_ops();
    saw_write = rb_en_write;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      saw_write |= rb_en_write;
    end
    n_cmp++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: err=%b busy=%b need 0,1", err_timeout, busy);
    end
    @(negedge clk);
    saw_write |= rb_en_write;
    n_cmp++;
    if (err_timeout !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || saw_write !== 1'b0 ||
        wb_count !== 8'd2 || bank[7] !== 16'hC0DE) begin
      n_bad++; $display("FAIL timeout_fire: err=%b rdy=%b busy=%b wrote=%b cnt=%0d bank7=%h need 1 1 0 0 2 c0de",
                        err_timeout, req_ready, busy, saw_write, wb_count, bank[7]);
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: err=%b need 0", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; op_exp_t e; wr_exp_t w;
    preload(3'd5, 16'h1111);
    op_q.push_back('{a: 16'h1111, b: 16'h1234});
    send_req(1'b1, REG_BP, REG_DX, REG_BP, 1'b1, ok);
    wait_op_valid(ok);
    e = op_q.pop_front();
    n_cmp++;
    if (!ok || op_a !== e.a || op_b !== e.b) begin
      n_bad++; $display("FAIL midrst_ops: ok=%0d a=%h b=%h need %h %h", ok, op_a, op_b, e.a, e.b);
    end
    issue_ops();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, op_valid, res_ready, busy, rb_en_write, err_timeout} !== 6'b100000 ||
        op_a !== 16'h0000 || op_b !== 16'h0000 || wb_count !== 8'd0 ||
        rb_reg_read1 !== 3'd0 || rb_reg_read2 !== 3'd0) begin
      n_bad++; $display("FAIL midrst_outputs: rdy=%b ov=%b rr=%b busy=%b we=%b a=%h cnt=%0d rd1=%0d",
                        req_ready, op_valid, res_ready, busy, rb_en_write, op_a, wb_count, rb_reg_read1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bank[5] !== 16'h1111) begin
      n_bad++; $display("FAIL midrst_nowrite: bank5=%h need 1111", bank[5]);
    end
    op_q.push_back('{a: 16'h1111, b: 16'h1234});
    wr_q.push_back('{idx: 3'd5, size: 1'b1, hl: 1'b0, data: 16'hBEEF});
    send_req(1'b1, REG_BP, REG_DX, REG_BP, 1'b1, ok);
    wait_op_valid(ok);
    e = op_q.pop_front();
    n_cmp++;
    if (!ok || op_a !== e.a || op_b !== e.b) begin
      n_bad++; $display("FAIL postrst_ops: ok=%0d a=%h b=%h need %h %h", ok, op_a, op_b, e.a, e.b);
    end
    issue_ops();
    res_valid = 1'b1; res_data = 16'hBEEF;
    @(negedge clk);
    res_valid = 1'b0;
    w = wr_q.pop_front();
    n_cmp++;
    if (rb_en_write !== 1'b1 ||
        {rb_reg_write, rb_size, rb_select_high_low, rb_write_data} !== {w.idx, w.size, w.hl, w.data}) begin
      n_bad++; $display("FAIL postrst_ctrl: we=%b idx=%0d sz=%b hl=%b d=%h need 1 %0d %b %b %h",
                        rb_en_write, rb_reg_write, rb_size, rb_select_high_low, rb_write_data, w.idx, w.size, w.hl, w.data);
    end
    @(negedge clk);
    n_cmp++;
    if (bank[5] !== 16'hBEEF || wb_count !== 8'd1 || rb_en_write !== 1'b0) begin
      n_bad++; $display("FAIL postrst_result: bank5=%h cnt=%0d we=%b need beef 1 0", bank[5], wb_count, rb_en_write);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_word_stall();
    test_byte_read();
    test_byte_wb();
    test_res_at_expiry();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
